nibble_sequencer: RTL and testbench

NIBBLE_SEQUENCER -- requirements
Module: nibble_sequencer

---
 rtl/nibble_sequencer.sv | 79 +++++++
 tb/tb_nibble_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_sequencer.sv
// Hex digit counter advanced by a programmable-rate tick divider.
// Supports direction control, parallel load and registered tick/wrap pulses.
module nibble_sequencer #(
   parameter int unsigned CLOCK_HZ = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       up,
   input  logic [1:0] speed,
   input  logic       load,
   input  logic [3:0] load_value,
   output logic [3:0] digit,
   output logic       tick,
   output logic       wrap
);

   localparam int unsigned DIV_W = $clog2(4 * CLOCK_HZ) + 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] reload_c;
   logic [3:0]       digit_q, digit_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;

   // Divider reload length, sampled only when a period starts
   always_comb begin
      case (speed)
         2'b00:   reload_c = '0;
         2'b01:   reload_c = DIV_W'(CLOCK_HZ - 1);
         2'b10:   reload_c = DIV_W'(2 * CLOCK_HZ - 1);
         default: reload_c = DIV_W'(4 * CLOCK_HZ - 1);
      endcase
   end

   always_comb begin
      div_d   = div_q;
      digit_d = digit_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      if (load) begin
         digit_d = load_value;
         div_d   = reload_c;
      end else if (enable) begin
         if (div_q == '0) begin
            tick_d = 1'b1;
            div_d  = reload_c;
            if (up) begin
               digit_d = digit_q + 4'd1;
               wrap_d  = (digit_q == 4'hF);
            end else begin
               digit_d = digit_q - 4'd1;
               wrap_d  = (digit_q == 4'h0);
            end
         end else begin
            div_d = div_q - DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_q   <= '0;
         digit_q <= '0;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         div_q   <= div_d;
         digit_q <= digit_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   assign digit = digit_q;
   assign tick  = tick_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_nibble_sequencer.sv
// Scoreboard bench for nibble_sequencer: stimulus queues expected ticks
// (cycle, digit, wrap); a negedge monitor pops and compares each tick.
module tb_nibble_sequencer;

   typedef struct {
      int         cyc;
      logic [3:0] digit;
      logic       wrap;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       up;
   logic [1:0] speed;
   logic       load;
   logic [3:0] load_value;
   logic [3:0] digit;
   logic       tick;
   logic       wrap;

   int   cyc    = 0;
   int   checks = 0;
   int   passes = 0;
   exp_t exp_q[$];

   nibble_sequencer #(.CLOCK_HZ(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .up         (up),
      .speed      (speed),
      .load       (load),
      .load_value (load_value),
      .digit      (digit),
      .tick       (tick),
      .wrap       (wrap)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act == req) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
   endtask

   function automatic void push(input int c, input logic [3:0] d, input logic w);
      exp_t e;
      e.cyc   = c;
      e.digit = d;
      e.wrap  = w;
      exp_q.push_back(e);
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Monitor: every tick must match the oldest queued expectation
   always @(negedge clock) begin
      exp_t e;
      if (wrap && !tick) chk("wrap_without_tick", 1, 0);
      if (tick) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_tick", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("tick_cycle", cyc, e.cyc);
            chk("tick_digit", int'(digit), int'(e.digit));
            chk("tick_wrap", int'(wrap), int'(e.wrap));
         end
      end
   end

   initial begin
      int c;
      reset = 1'b1; load = 1'b1; load_value = 4'h7;
      enable = 1'b1; up = 1'b1; speed = 2'b01;

      // Reset holds everything at zero even with load asserted
      step(2);
      chk("reset_digit", int'(digit), 0);
      chk("reset_tick", int'(tick), 0);
      chk("reset_wrap", int'(wrap), 0);

      // Release: first tick on first edge, then every 4 cycles
      reset = 1'b0; load = 1'b0;
      c = cyc;
      push(c + 1, 4'h1, 1'b0);
      push(c + 5, 4'h2, 1'b0);
      push(c + 9, 4'h3, 1'b0);
      push(c + 13, 4'h4, 1'b0);
      step(14);

      // Load E then count up every cycle, wrapping F->0
      c = cyc;
      speed = 2'b00; load = 1'b1; load_value = 4'hE;
      step(1);
      chk("load_e_digit", int'(digit), 14);
      chk("load_no_tick", int'(tick), 0);
      load = 1'b0;
      push(c + 2, 4'hF, 1'b0);
      push(c + 3, 4'h0, 1'b1);
      push(c + 4, 4'h1, 1'b0);
      step(3);
      enable = 1'b0;
      step(1);

      // Down from 0: wraps to F, then E, D
      c = cyc;
      load = 1'b1; load_value = 4'h0;
      step(1);
      load = 1'b0; up = 1'b0; enable = 1'b1;
      push(c + 2, 4'hF, 1'b1);
      push(c + 3, 4'hE, 1'b0);
      push(c + 4, 4'hD, 1'b0);
      step(3);
      enable = 1'b0;
      step(1);

      // Speed 11 period completes despite switching to 00 mid-period
      c = cyc;
      load = 1'b1; load_value = 4'h5; speed = 2'b11; up = 1'b1;
      step(1);
      load = 1'b0; enable = 1'b1;
      step(3);
      speed = 2'b00;
      push(c + 17, 4'h6, 1'b0);
      push(c + 18, 4'h7, 1'b0);
      push(c + 19, 4'h8, 1'b0);
      step(15);
      enable = 1'b0;
      step(1);

      // Enable low for 10 cycles freezes the period mid-way
      c = cyc;
      load = 1'b1; load_value = 4'h3; speed = 2'b01;
      step(1);
      load = 1'b0; enable = 1'b1;
      step(2);
      enable = 1'b0;
      step(10);
      chk("freeze_digit", int'(digit), 3);
      chk("freeze_tick", int'(tick), 0);
      enable = 1'b1;
      push(c + 15, 4'h4, 1'b0);
      step(2);

      // Load held three cycles tracks load_value, then a full period
      c = cyc;
      load = 1'b1; load_value = 4'hA;
      step(1);
      chk("hold_load_a", int'(digit), 10);
      load_value = 4'hB;
      step(1);
      chk("hold_load_b", int'(digit), 11);
      load_value = 4'hC;
      step(1);
      chk("hold_load_c", int'(digit), 12);
      load = 1'b0;
      push(c + 7, 4'hD, 1'b0);
      step(4);
      enable = 1'b0;
      step(1);

      // Asynchronous reset between edges while digit=9 and tick high
      c = cyc;
      load = 1'b1; load_value = 4'h8; speed = 2'b00;
      step(1);
      load = 1'b0; enable = 1'b1;
      push(c + 2, 4'h9, 1'b0);
      step(1);
      chk("pre_reset_digit", int'(digit), 9);
      #2;
      reset = 1'b1; load = 1'b1; load_value = 4'h7;
      #1;
      chk("async_reset_digit", int'(digit), 0);
      chk("async_reset_tick", int'(tick), 0);
      chk("async_reset_wrap", int'(wrap), 0);
      step(1);
      chk("reset_ignores_load", int'(digit), 0);

      // After release the first edge ticks immediately
      c = cyc;
      reset = 1'b0; load = 1'b0; speed = 2'b01; up = 1'b1; enable = 1'b1;
      push(c + 1, 4'h1, 1'b0);
      push(c + 5, 4'h2, 1'b0);
      step(5);
      enable = 1'b0;
      step(3);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
